// File: rtl/seg_scan_driver.sv
// Multiplexed 4-digit 7-segment scan driver: walks units->thousands one slot at a time,
// decoding a per-frame snapshot of the BCD inputs with optional leading-zero blanking.
module seg_scan_driver #(
    parameter int SCAN_DIV = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       blank_en,
    input  logic [3:0] thousand,
    input  logic [3:0] hundred,
    input  logic [3:0] tens,
    input  logic [3:0] units,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       frame_start
);

    localparam logic [15:0] PRESC_LAST = 16'(SCAN_DIV - 1);
    localparam logic [6:0]  SEG_OFF    = 7'b1111111;

    logic [15:0] presc;
    logic [1:0]  idx;
    logic [3:0]  snap_th, snap_hu, snap_te, snap_un;
    logic        tick;
    logic [3:0]  cur_digit;
    logic        blank_digit;
    logic [6:0]  seg_next;
    logic [3:0]  an_next;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111110;
        endcase
        return s;
    endfunction

    assign tick = (presc == PRESC_LAST);

    // Decode always reads the snapshot so a frame never mixes two counter values.
    always_comb begin
        cur_digit   = snap_un;
        blank_digit = 1'b0;
        case (idx)
            2'd0: cur_digit = snap_un;
            2'd1: begin
                cur_digit   = snap_te;
                blank_digit = (snap_th == 4'd0) && (snap_hu == 4'd0) && (snap_te == 4'd0);
            end
            2'd2: begin
                cur_digit   = snap_hu;
                blank_digit = (snap_th == 4'd0) && (snap_hu == 4'd0);
            end
            default: begin
                cur_digit   = snap_th;
                blank_digit = (snap_th == 4'd0);
            end
        endcase
        seg_next = (blank_en && blank_digit) ? SEG_OFF : decode(cur_digit);
        an_next  = 4'b0001 << idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc       <= '0;
            idx         <= '0;
            snap_th     <= '0;
            snap_hu     <= '0;
            snap_te     <= '0;
            snap_un     <= '0;
            an          <= '0;
            seg         <= SEG_OFF;
            frame_start <= 1'b0;
        end else if (!en) begin
            // Disabled: blank and keep the snapshot tracking so re-enable shows fresh digits.
            presc       <= '0;
            idx         <= '0;
            snap_th     <= thousand;
            snap_hu     <= hundred;
            snap_te     <= tens;
            snap_un     <= units;
            an          <= '0;
            seg         <= SEG_OFF;
            frame_start <= 1'b0;
        end else begin
            an          <= an_next;
            seg         <= seg_next;
            frame_start <= tick && (idx == 2'd3);
            if (tick) begin
                presc <= '0;
                idx   <= idx + 2'd1;
                if (idx == 2'd3) begin
                    snap_th <= thousand;
                    snap_hu <= hundred;
                    snap_te <= tens;
                    snap_un <= units;
                end
            end else begin
                presc <= presc + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with SCAN_DIV=4: table of digit/blanking vectors
// plus hand-written sequences for mid-frame changes, enable drop and reset on a tick.
module tb_seg_scan_driver;

    localparam int SCAN_DIV = 4;

    logic       clk = 1'b0;
    logic       rst, en, blank_en;
    logic [3:0] thousand, hundred, tens, units;
    logic [6:0] seg;
    logic [3:0] an;
    logic       frame_start;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg_scan_driver #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .rst(rst), .en(en), .blank_en(blank_en),
        .thousand(thousand), .hundred(hundred), .tens(tens), .units(units),
        .seg(seg), .an(an), .frame_start(frame_start)
    );

    typedef struct {
        logic [3:0] th, hu, te, un;
        logic       bl;
        logic [6:0] s0, s1, s2, s3;  // expected seg for units, tens, hundreds, thousands
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b expected %b", name, act, exp);
        end
    endtask

    // One frame is 16 cycles: 4 per slot, frame_start on the last cycle of the frame.
    task automatic run_frame(input string name, input logic [6:0] e0, input logic [6:0] e1,
                             input logic [6:0] e2, input logic [6:0] e3, input bit do_seg,
                             input int n_steps, input int chg_at, input logic [15:0] chg_val);
        logic [6:0] es;
        logic [3:0] ea;
        for (int t = 0; t < n_steps; t++) begin
            step();
            case (t / 4)
                0:       es = e0;
                1:       es = e1;
                2:       es = e2;
                default: es = e3;
            endcase
            ea = 4'(1 << (t / 4));
            chk($sformatf("%s an t%0d", name, t), {3'b000, an}, {3'b000, ea});
            if (do_seg) chk($sformatf("%s seg t%0d", name, t), seg, es);
            chk($sformatf("%s frame_start t%0d", name, t), {6'd0, frame_start}, {6'd0, (t == 15)});
            if (t == chg_at) {thousand, hundred, tens, units} = chg_val;
        end
    endtask

    initial begin
        vecs[0] = '{4'd1, 4'd2, 4'd3, 4'd4,  1'b0, 7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
        vecs[1] = '{4'd0, 4'd0, 4'd0, 4'd7,  1'b1, 7'b0001111, 7'b1111111, 7'b1111111, 7'b1111111};
        vecs[2] = '{4'd0, 4'd0, 4'd0, 4'd0,  1'b1, 7'b0000001, 7'b1111111, 7'b1111111, 7'b1111111};
        vecs[3] = '{4'd5, 4'd6, 4'd7, 4'd8,  1'b0, 7'b0000000, 7'b0001111, 7'b0100000, 7'b0100100};
        vecs[4] = '{4'd0, 4'd9, 4'd0, 4'hC,  1'b1, 7'b1111110, 7'b0000001, 7'b0000100, 7'b1111111};
        vecs[5] = '{4'd0, 4'd0, 4'd5, 4'd0,  1'b1, 7'b0000001, 7'b0100100, 7'b1111111, 7'b1111111};
        vecs[6] = '{4'hF, 4'hA, 4'd0, 4'd0,  1'b1, 7'b0000001, 7'b0000001, 7'b1111110, 7'b1111110};
        vecs[7] = '{4'd0, 4'd0, 4'd0, 4'd9,  1'b0, 7'b0000100, 7'b0000001, 7'b0000001, 7'b0000001};

        rst = 1'b1; en = 1'b1; blank_en = 1'b0;
        {thousand, hundred, tens, units} = 16'h1234;
        step();
        chk("reset an", {3'b000, an}, 7'd0);
        chk("reset seg", seg, 7'b1111111);
        chk("reset frame_start", {6'd0, frame_start}, 7'd0);
        rst = 1'b0;

        // First frame shows the zeroed snapshot; 1234 appears only after frame_start.
        run_frame("boot", 7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001, 1'b1, 16, -1, 16'h0);
        run_frame("f1234", 7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111, 1'b1, 16, -1, 16'h0);

        for (int i = 0; i < 8; i++) begin
            {thousand, hundred, tens, units} = {vecs[i].th, vecs[i].hu, vecs[i].te, vecs[i].un};
            blank_en = vecs[i].bl;
            run_frame($sformatf("vec%0d load", i), vecs[i].s0, vecs[i].s1, vecs[i].s2, vecs[i].s3,
                      1'b0, 16, -1, 16'h0);
            run_frame($sformatf("vec%0d show", i), vecs[i].s0, vecs[i].s1, vecs[i].s2, vecs[i].s3,
                      1'b1, 16, -1, 16'h0);
        end

        // Inputs change mid-frame: the frame in progress keeps the old snapshot.
        {thousand, hundred, tens, units} = 16'h1234;
        blank_en = 1'b0;
        run_frame("mid load", 7'b0, 7'b0, 7'b0, 7'b0, 1'b0, 16, -1, 16'h0);
        run_frame("mid old", 7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111, 1'b1, 16, 5, 16'h5678);
        run_frame("mid new", 7'b0000000, 7'b0001111, 7'b0100000, 7'b0100100, 1'b1, 16, -1, 16'h0);

        // Drop enable while hundreds is lit, then re-enable with new digits.
        run_frame("pre dis", 7'b0000000, 7'b0001111, 7'b0100000, 7'b0100100, 1'b1, 9, -1, 16'h0);
        en = 1'b0;
        {thousand, hundred, tens, units} = 16'h0003;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("dis an c%0d", k), {3'b000, an}, 7'd0);
            chk($sformatf("dis seg c%0d", k), seg, 7'b1111111);
            chk($sformatf("dis frame_start c%0d", k), {6'd0, frame_start}, 7'd0);
        end
        en = 1'b1;
        run_frame("reen", 7'b0000110, 7'b0000001, 7'b0000001, 7'b0000001, 1'b1, 16, -1, 16'h0);

        // Reset lands on the tick that would wrap index 3 -> 0.
        {thousand, hundred, tens, units} = 16'h1234;
        run_frame("pre rst", 7'b0000110, 7'b0000001, 7'b0000001, 7'b0000001, 1'b1, 15, -1, 16'h0);
        rst = 1'b1;
        step();
        chk("tick rst an", {3'b000, an}, 7'd0);
        chk("tick rst seg", seg, 7'b1111111);
        chk("tick rst frame_start", {6'd0, frame_start}, 7'd0);
        rst = 1'b0;
        run_frame("post rst", 7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001, 1'b1, 16, -1, 16'h0);
        run_frame("post rst show", 7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111, 1'b1, 16, -1, 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 5000, clk cycles per digit slot (5 MHz -> 1 kHz digit rate); legal range 2..65535.
REQ-002 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port en  input  1  scan enable; low blanks the display.
REQ-005 SHALL have port blank_en  input  1  leading-zero blanking enable.
REQ-006 SHALL have ports thousand, hundred, tens, units  input  4 each  BCD digits from the upstream 4-digit counter.
REQ-007 SHALL have port seg  output  7  segments {a,b,c,d,e,f,g}, active-low.
REQ-008 SHALL have port an  output  4  one-hot digit select, active-high; bit0 units, bit1 tens, bit2 hundreds, bit3 thousands.
REQ-009 SHALL have port frame_start  output  1  one-cycle pulse when a new frame snapshot is taken.

Function
REQ-010 SHALL count prescaler 0..SCAN_DIV-1 while en=1 and generate an internal tick at SCAN_DIV-1, then wrap to 0.
REQ-011 SHALL hold a 2-bit digit index 0..3, advancing by 1 mod 4 on each tick.
REQ-012 SHALL copy all four digit inputs into a snapshot register on every tick that moves the index 3->0, and pulse frame_start high in the same cycle the snapshot is written.
REQ-013 SHALL decode only snapshot digits, never live inputs, so no frame mixes two counter values.
REQ-014 SHALL register seg and an: each equals the decode of the index/snapshot from the previous cycle (1-cycle latency).
REQ-015 SHALL encode active-low digits 0..9 as 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100.
REQ-016 SHALL output dash 1111110 for any snapshot digit value 10..15.
REQ-017 SHALL, when blank_en=1, output 1111111 for thousands if zero, hundreds if thousands and hundreds are zero, and tens if the three upper digits are zero; units are never blanked.
REQ-018 SHALL keep an one-hot during blanking; only seg goes to 1111111.
REQ-019 SHALL, while en=0, hold prescaler and index at 0, drive an=0000 and seg=1111111, keep frame_start at 0, and load the snapshot from inputs every cycle.
REQ-020 SHALL, on en rising, start at index 0 with prescaler 0, showing units on the next cycle from the snapshot loaded while disabled.
REQ-021 SHALL sample blank_en combinationally against the snapshot each cycle; changes take effect on the next registered output.

Reset
REQ-022 SHALL, with rst=1 at a clk edge, set prescaler=0, index=0, snapshot=0, an=0000, seg=1111111, frame_start=0.
REQ-023 SHALL give rst priority over en and tick in the same cycle, including a reset arriving mid-slot or mid-frame.
REQ-024 SHALL, in the first cycle after rst deasserts with en=1, drive an=0001 and seg=0000001 (snapshot 0).

Verification (SCAN_DIV=4)
REQ-025 SHALL check reset then en=1 with digits 1,2,3,4 -> an sequence 0001,0010,0100,1000 at 4 cycles each; new digits appear only after the first frame_start; then seg=1001100,0000110,0010010,1001111.
REQ-026 SHALL check blank_en=1 with digits 0,0,0,7 -> thousands/hundreds/tens seg=1111111, units seg=0001111; digits 0,0,0,0 -> units 0000001.
REQ-027 SHALL check digits changed mid-frame from 1234 to 5678 -> the rest of the frame still shows 1234, 5678 is shown after frame_start.
REQ-028 SHALL check units=4'hC -> units seg=1111110.
REQ-029 SHALL check en dropped while an=0100 -> next cycle an=0000 and seg=1111111; en re-raised -> an=0001 after one cycle.
REQ-030 SHALL check rst asserted on a tick cycle at index 3 -> no frame_start, all outputs at reset values the next cycle.
